// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Brief    : Shares one SRAM-like bus port between instruction fetch and the
//            load/store data requester, one transaction in flight at a time.
//            Optional macro ARB_RR_EN selects round-robin arbitration on
//            simultaneous requests; otherwise data has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic c_OWNER_INST = 1'b0;
    localparam logic c_OWNER_DATA = 1'b1;

    state_t      r_state;
    logic        r_owner;
    logic        r_bus_req;
    logic        r_bus_wr;
    logic [1:0]  r_bus_size;
    logic [3:0]  r_bus_wstrb;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;

    logic        w_idle;
    logic        w_grant_data;
    logic        w_grant_inst;
    logic        w_complete;

    assign w_idle = (r_state == ST_IDLE);

`ifdef ARB_RR_EN
    logic r_last_grant;

    // On a tie, data wins only if instruction fetch was granted last.
    assign w_grant_data = data_req & (~inst_req | (r_last_grant == c_OWNER_INST));
`else
    assign w_grant_data = data_req;
`endif
    assign w_grant_inst = inst_req & ~w_grant_data;

    assign inst_addr_ok = w_idle & w_grant_inst;
    assign data_addr_ok = w_idle & w_grant_data;

    // A transaction ends either on a combined addr/data handshake or in DATA.
    assign w_complete = ((r_state == ST_ADDR) & bus_addr_ok & bus_data_ok) |
                        ((r_state == ST_DATA) & bus_data_ok);

    assign inst_data_ok = bus_data_ok & w_complete & (r_owner == c_OWNER_INST);
    assign data_data_ok = bus_data_ok & w_complete & (r_owner == c_OWNER_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    assign bus_req   = r_bus_req;
    assign bus_wr    = r_bus_wr;
    assign bus_size  = r_bus_size;
    assign bus_wstrb = r_bus_wstrb;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_owner     <= c_OWNER_INST;
            r_bus_req   <= 1'b0;
            r_bus_wr    <= 1'b0;
            r_bus_size  <= 2'd0;
            r_bus_wstrb <= 4'd0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_data) begin
                        r_bus_req   <= 1'b1;
                        r_bus_wr    <= data_wr;
                        r_bus_size  <= data_size;
                        r_bus_wstrb <= data_wstrb;
                        r_bus_addr  <= data_addr;
                        r_bus_wdata <= data_wdata;
                        r_owner     <= c_OWNER_DATA;
                        r_state     <= ST_ADDR;
                    end else if (w_grant_inst) begin
                        r_bus_req   <= 1'b1;
                        r_bus_wr    <= 1'b0;
                        r_bus_size  <= 2'd2;
                        r_bus_wstrb <= 4'd0;
                        r_bus_addr  <= inst_addr;
                        r_bus_wdata <= 32'd0;
                        r_owner     <= c_OWNER_INST;
                        r_state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus_addr_ok) begin
                        r_bus_req <= 1'b0;
                        r_state   <= bus_data_ok ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bus_data_ok) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_bus_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_grant <= c_OWNER_INST;
        end else if (w_idle & (w_grant_data | w_grant_inst)) begin
            r_last_grant <= w_grant_data ? c_OWNER_DATA : c_OWNER_INST;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
# sram_arbiter

Shares one SRAM-like memory port between the instruction-fetch requester and the load/store unit's data requester. It sits between the core and the memory bus bridge. The block accepts at most one transaction at a time. It latches the granted request, presents it on the shared bus until the address is accepted, then waits for the data phase and steers the response back to the owner.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request (read only)
- inst_addr  in  32  fetch byte address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch read data valid this cycle
- inst_rdata  out  32  fetch read data
- data_req  in  1  load/store request
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  byte write enables, stores only
- data_addr  in  32  data byte address
- data_wdata  in  32  store data, already lane-replicated
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  load data valid / store complete this cycle
- data_rdata  out  32  raw load data; extension is done downstream
- bus_req, bus_wr  out  1  shared-bus request and direction
- bus_size  out  2  shared-bus transfer size
- bus_wstrb  out  4  shared-bus byte write enables
- bus_addr, bus_wdata  out  32  shared-bus address and write data
- bus_addr_ok, bus_data_ok  in  1  bus handshake responses
- bus_rdata  in  32  bus read data

## Operation
- FSM states: IDLE, ADDR, DATA. The block also holds an owner register (INST/DATA) and a latched request (wr, size, wstrb, addr, wdata).
- IDLE:
  - If any request is pending, select a winner and pulse its *_addr_ok combinationally in the same cycle.
  - Latch the winner's fields, record the owner, and go to ADDR.
  - Fetch latches as wr=0, size=2, wstrb=0, wdata=0.
  - The loser sees addr_ok=0 and must hold its request.
- ADDR:
  - Drive bus_req=1 with the latched fields.
  - On bus_addr_ok, go to DATA.
  - If bus_addr_ok and bus_data_ok arrive in the same cycle, complete immediately and return to IDLE.
- DATA:
  - Drive bus_req=0.
  - On bus_data_ok, pulse the owner's *_data_ok and return to IDLE.
- Response steering:
  - inst_data_ok = bus_data_ok & completing & owner==INST; data_data_ok likewise for DATA.
  - inst_rdata and data_rdata are both driven from bus_rdata combinationally.
- New requests are never accepted in ADDR or DATA; *_addr_ok stays 0 in those states. There is no overlap of transactions.
- bus_data_ok in IDLE, or without bus_addr_ok while in ADDR, is ignored.
- Priority: a fixed data-over-inst priority applies unless ARB_RR_EN is defined (see Configuration).

## Timing
- Reset values:
  - state=IDLE, owner=INST, latched fields all 0, last-grant=INST.
  - bus_req=0, bus_wr=0, bus_size=0, bus_wstrb=0, bus_addr=0, bus_wdata=0.
  - All *_addr_ok and *_data_ok = 0.
- Request at cycle 0 in IDLE:
  - addr_ok at cycle 0.
  - bus_req first high at cycle 1.
  - Earliest *_data_ok at cycle 1 (same-cycle addr/data ok). Typical is cycle 2.
  - Next grant possible in the cycle after data_ok.
- bus_* outputs are registered. They hold stable while bus_req=1 until bus_addr_ok.
- Async reset mid-transaction:
  - Return to IDLE immediately and drop the outstanding transaction.
  - No data_ok is issued for it.

## Configuration
- ARB_RR_EN defined:
  - Round-robin on simultaneous requests: grant the requester other than last-grant.
  - last-grant updates on every grant.
  - A single requester is always granted.
- ARB_RR_EN undefined:
  - Fixed priority: data_req always wins over inst_req.
  - The last-grant register is not built.

## Test plan
- Single load: data_req, wr=0, addr=0x1000_0004. Bus gives addr_ok at cycle 2 and data_ok at cycle 4 with rdata=0xDEAD_BEEF. Required: data_addr_ok at cycle 0, data_data_ok at cycle 4 with data_rdata=0xDEAD_BEEF, inst_data_ok never high.
- Store byte: wr=1, size=0, wstrb=0b0001, wdata=0x5A5A_5A5A. Required: bus_wr=1, bus_size=0, bus_wstrb=0b0001, and bus_wdata held until bus_addr_ok.
- Simultaneous inst_req and data_req, repeated 4 times:
  - Fixed priority: data granted all 4 times.
  - With ARB_RR_EN: grants alternate DATA, INST, DATA, INST.
- Same-cycle bus_addr_ok and bus_data_ok in ADDR: owner data_ok is asserted that cycle, and the block is back in IDLE next cycle.
- resetn low while in DATA with a fetch outstanding: state=IDLE, bus_req=0, no inst_data_ok. A later bus_data_ok is ignored.
- A new request arriving in the ADDR or DATA state: addr_ok stays 0 until IDLE, then is granted.
